// File: rtl/ssd_ahb_pkg.sv
// Shared AHB-Lite constants, seven-segment display register map, status codes and
// writer FSM states.
package ssd_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    localparam logic [31:0] SSD_DATA_ADDR = 32'hD000_0000;
    localparam logic [31:0] SSD_FLAG_ADDR = 32'hD000_0004;
    localparam logic [4:0]  SSD_SAT_CODE  = 5'd31;

    localparam logic [1:0] STATUS_OK       = 2'd0;
    localparam logic [1:0] STATUS_BUS_ERR  = 2'd1;
    localparam logic [1:0] STATUS_MISMATCH = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StAData,
        StAFlag,
        StARead,
        StLast,
        StErr
    } ssd_state_e;

    // Classes above the highest letter index all collapse onto one display code.
    function automatic logic [4:0] ssd_map_class(input logic [7:0] cls,
                                                 input logic [7:0] max_class,
                                                 input logic [4:0] sat_code);
        return (cls > max_class) ? sat_code : cls[4:0];
    endfunction

endpackage

// File: rtl/ssd_result_writer.sv
// AHB-Lite initiator that publishes a classifier result to the seven-segment display:
// data write, done-flag write, then an optional readback of the data register.
module ssd_result_writer
    import ssd_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SSD_DATA_ADDR,
    parameter logic [7:0]  MAX_CLASS = 8'd23,
    parameter logic [4:0]  SAT_CODE  = SSD_SAT_CODE,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        result_valid_i,
    input  logic [7:0]  result_class_i,
    output logic        result_ready_o,
    output logic        done_o,
    output logic [1:0]  status_o,

    output logic [31:0] ahb_haddr_o,
    output logic        ahb_hwrite_o,
    output logic [2:0]  ahb_hsize_o,
    output logic [2:0]  ahb_hburst_o,
    output logic [3:0]  ahb_hprot_o,
    output logic [1:0]  ahb_htrans_o,
    output logic        ahb_hmastlock_o,
    output logic [31:0] ahb_hwdata_o,
    input  logic [31:0] ahb_hrdata_i,
    input  logic        ahb_hready_i,
    input  logic        ahb_hresp_i
);

    ssd_state_e  r_state;
    logic [4:0]  r_code;
    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [1:0]  r_htrans;
    logic [31:0] r_hwdata;
    logic        r_ready;
    logic        r_done;
    logic [1:0]  r_status;

    logic [4:0]  w_code;
    logic        w_bus_err;
    logic        w_unused;

    assign w_code    = ssd_map_class(result_class_i, MAX_CLASS, SAT_CODE);
    // First cycle of a two-cycle ERROR response; the second cycle has hready high.
    assign w_bus_err = (r_state != StIdle) && ahb_hresp_i && !ahb_hready_i;
    assign w_unused  = ^ahb_hrdata_i[31:5];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_code   <= '0;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_htrans <= HTRANS_IDLE;
            r_hwdata <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_status <= STATUS_OK;
        end else begin
            r_done <= 1'b0;
            if (w_bus_err) begin
                // Cancel whatever address phase is pending and wait out the response.
                r_state  <= StErr;
                r_htrans <= HTRANS_IDLE;
                r_hwrite <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (result_valid_i && r_ready) begin
                            r_code   <= w_code;
                            r_state  <= StAData;
                            r_ready  <= 1'b0;
                            r_haddr  <= BASE_ADDR;
                            r_hwrite <= 1'b1;
                            r_htrans <= HTRANS_NONSEQ;
                        end
                    end
                    StAData: begin
                        if (ahb_hready_i) begin
                            r_state  <= StAFlag;
                            r_haddr  <= BASE_ADDR + 32'd4;
                            r_hwdata <= {27'b0, r_code};
                        end
                    end
                    StAFlag: begin
                        if (ahb_hready_i) begin
                            r_hwdata <= 32'd1;
                            r_hwrite <= 1'b0;
                            if (VERIFY) begin
                                r_state <= StARead;
                                r_haddr <= BASE_ADDR;
                            end else begin
                                r_state  <= StLast;
                                r_htrans <= HTRANS_IDLE;
                            end
                        end
                    end
                    StARead: begin
                        if (ahb_hready_i) begin
                            r_state  <= StLast;
                            r_htrans <= HTRANS_IDLE;
                        end
                    end
                    StLast: begin
                        if (ahb_hready_i) begin
                            r_state <= StIdle;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            if (VERIFY && (ahb_hrdata_i[4:0] != r_code)) begin
                                r_status <= STATUS_MISMATCH;
                            end else begin
                                r_status <= STATUS_OK;
                            end
                        end
                    end
                    StErr: begin
                        if (ahb_hready_i) begin
                            r_state  <= StIdle;
                            r_ready  <= 1'b1;
                            r_done   <= 1'b1;
                            r_status <= STATUS_BUS_ERR;
                        end
                    end
                    default: begin
                        r_state  <= StIdle;
                        r_ready  <= 1'b1;
                        r_htrans <= HTRANS_IDLE;
                    end
                endcase
            end
        end
    end

    assign result_ready_o  = r_ready;
    assign done_o          = r_done;
    assign status_o        = r_status;

    assign ahb_haddr_o     = r_haddr;
    assign ahb_hwrite_o    = r_hwrite;
    assign ahb_htrans_o    = r_htrans;
    assign ahb_hwdata_o    = r_hwdata;
    assign ahb_hsize_o     = HSIZE_WORD;
    assign ahb_hburst_o    = HBURST_SINGLE;
    assign ahb_hprot_o     = HPROT_DATA;
    assign ahb_hmastlock_o = 1'b0;

endmodule

// File: tb/tb_ssd_result_writer.sv
// Self-checking bench: AHB-Lite slave model with programmable waits, errors and readback
// corruption, plus a transaction-level reference of the expected bus traffic and results.
module tb_ssd_result_writer;
    import ssd_ahb_pkg::*;

    localparam logic [31:0] BASE = 32'hD000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        result_valid_i;
    logic [7:0]  result_class_i;
    logic        result_ready_o;
    logic        done_o;
    logic [1:0]  status_o;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    ssd_result_writer #(
        .BASE_ADDR(BASE),
        .MAX_CLASS(8'd23),
        .SAT_CODE (5'd31),
        .VERIFY   (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .result_valid_i (result_valid_i),
        .result_class_i (result_class_i),
        .result_ready_o (result_ready_o),
        .done_o         (done_o),
        .status_o       (status_o),
        .ahb_haddr_o    (haddr),
        .ahb_hwrite_o   (hwrite),
        .ahb_hsize_o    (hsize),
        .ahb_hburst_o   (hburst),
        .ahb_hprot_o    (hprot),
        .ahb_htrans_o   (htrans),
        .ahb_hmastlock_o(hmastlock),
        .ahb_hwdata_o   (hwdata),
        .ahb_hrdata_i   (hrdata),
        .ahb_hready_i   (hready),
        .ahb_hresp_i    (hresp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: expected transfers still to be issued and the result in flight.
    xfer_t       exp_q[$];
    bit          m_busy;
    logic [4:0]  m_code;
    bit          exp_done;
    logic [1:0]  exp_status;
    int          cyc;

    // Slave state for the transfer currently in its data phase.
    bit          dp_act;
    xfer_t       dp;
    int          dp_wait;
    bit          dp_err;
    bit          err_stage;
    int          seq_idx;
    logic [31:0] mem_data;
    logic [31:0] mem_flag;

    int          cfg_wait[3];
    int          cfg_err;
    logic [31:0] cfg_xor;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t x;
        x.addr = a;
        x.wr   = w;
        x.data = d;
        return x;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        m_busy    = 1'b0;
        exp_done  = 1'b0;
        dp_act    = 1'b0;
        err_stage = 1'b0;
        dp_wait   = 0;
        dp_err    = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_haddr"}, haddr, 32'h0);
        check_eq({tag, "_hwrite"}, 32'(hwrite), 32'h0);
        check_eq({tag, "_htrans"}, 32'(htrans), 32'(HTRANS_IDLE));
        check_eq({tag, "_hwdata"}, hwdata, 32'h0);
        check_eq({tag, "_hsize"}, 32'(hsize), 32'h2);
        check_eq({tag, "_hburst"}, 32'(hburst), 32'h0);
        check_eq({tag, "_hprot"}, 32'(hprot), 32'h3);
        check_eq({tag, "_hmastlock"}, 32'(hmastlock), 32'h0);
        check_eq({tag, "_ready"}, 32'(result_ready_o), 32'h1);
        check_eq({tag, "_done"}, 32'(done_o), 32'h0);
        check_eq({tag, "_status"}, 32'(status_o), 32'h0);
    endtask

    // One bus cycle, called at the falling edge once the inputs for this cycle are set.
    task automatic step();
        bit    busy0;
        bit    fin;
        xfer_t x;
        cyc++;
        check_eq("done_o", 32'(done_o), 32'(exp_done));
        if (exp_done) check_eq("status_o", 32'(status_o), 32'(exp_status));
        check_eq("ready_o", 32'(result_ready_o), 32'(!m_busy));
        if (dp_act && err_stage) begin
            check_eq("htrans_after_err", 32'(htrans), 32'(HTRANS_IDLE));
        end else if (m_busy && exp_q.size() > 0) begin
            check_eq("htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
            check_eq("haddr", haddr, exp_q[0].addr);
            check_eq("hwrite", 32'(hwrite), 32'(exp_q[0].wr));
        end else begin
            check_eq("htrans_idle", 32'(htrans), 32'(HTRANS_IDLE));
        end
        if (dp_act && dp.wr && !err_stage) check_eq("hwdata", hwdata, dp.data);

        exp_done = 1'b0;
        busy0    = m_busy;
        fin      = 1'b0;
        if (dp_act) begin
            if (dp_wait > 0) begin
                hready = 1'b0;
                hresp  = 1'b0;
                dp_wait--;
            end else if (dp_err && !err_stage) begin
                hready    = 1'b0;
                hresp     = 1'b1;
                err_stage = 1'b1;
            end else begin
                hready = 1'b1;
                hresp  = dp_err;
                fin    = 1'b1;
            end
        end else begin
            hready = 1'b1;
            hresp  = 1'b0;
        end
        hrdata = (dp_act && !dp.wr) ? (mem_data ^ cfg_xor) : $urandom();

        if (fin) begin
            dp_act    = 1'b0;
            err_stage = 1'b0;
            if (dp_err) begin
                exp_q.delete();
                m_busy     = 1'b0;
                exp_done   = 1'b1;
                exp_status = STATUS_BUS_ERR;
            end else begin
                if (dp.wr && dp.addr == BASE) mem_data = hwdata;
                if (dp.wr && dp.addr == BASE + 32'd4) mem_flag = hwdata;
                if (exp_q.size() == 0) begin
                    m_busy     = 1'b0;
                    exp_done   = 1'b1;
                    exp_status = (hrdata[4:0] != m_code) ? STATUS_MISMATCH : STATUS_OK;
                end
            end
        end

        if (hready && htrans == HTRANS_NONSEQ && exp_q.size() > 0) begin
            x         = exp_q.pop_front();
            dp        = x;
            dp_act    = 1'b1;
            dp_wait   = cfg_wait[seq_idx];
            dp_err    = (cfg_err == seq_idx);
            err_stage = 1'b0;
            seq_idx++;
        end

        if (result_valid_i && !busy0) begin
            m_busy  = 1'b1;
            m_code  = (result_class_i > 8'd23) ? 5'd31 : 5'(result_class_i % 8'd32);
            seq_idx = 0;
            exp_q.push_back(mk(BASE, 1'b1, {27'b0, m_code}));
            exp_q.push_back(mk(BASE + 32'd4, 1'b1, 32'd1));
            exp_q.push_back(mk(BASE, 1'b0, 32'd0));
        end
    endtask

    task automatic run_one(input string tag, input logic [7:0] cls, input int w1,
                           input int err_idx, input logic [31:0] xr, input int exp_lat,
                           input int exp_st, input logic [31:0] exp_mem);
        int acc;
        int dn;
        cfg_wait = '{0, w1, 0};
        cfg_err  = err_idx;
        cfg_xor  = xr;
        acc      = -1;
        dn       = -1;
        for (int i = 0; i < 40 && dn < 0; i++) begin
            @(negedge clk);
            result_valid_i = (i == 0);
            result_class_i = cls;
            step();
            if (result_valid_i && result_ready_o) acc = cyc;
            if (done_o) begin
                dn = cyc;
                check_eq({tag, "_status"}, 32'(status_o), 32'(exp_st));
            end
        end
        check_eq({tag, "_latency"}, 32'(dn - acc), 32'(exp_lat));
        check_eq({tag, "_mem"}, mem_data, exp_mem);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc1;
        int acc2;
        int done1;
        int dones;
        cyc            = 0;
        mem_data       = $urandom();
        mem_flag       = 32'h0;
        cfg_wait       = '{0, 0, 0};
        cfg_err        = -1;
        cfg_xor        = 32'h0;
        clear_model();
        reset          = 1'b1;
        result_valid_i = 1'b0;
        result_class_i = 8'd0;
        hready         = 1'b1;
        hresp          = 1'b0;
        hrdata         = 32'h0;
        repeat (2) @(negedge clk);
        reset_checks("rst");
        reset = 1'b0;

        run_one("cls15", 8'd15, 0, -1, 32'h0, 5, 0, 32'd15);
        check_eq("cls15_flag", mem_flag, 32'd1);
        run_one("cls40", 8'd40, 0, -1, 32'h0, 5, 0, 32'd31);
        run_one("cls23", 8'd23, 0, -1, 32'h0, 5, 0, 32'd23);
        run_one("cls24", 8'd24, 0, -1, 32'h0, 5, 0, 32'd31);
        run_one("wait3", 8'd7, 3, -1, 32'h0, 8, 0, 32'd7);
        mem_data = 32'hA5;
        mem_flag = 32'h0;
        run_one("err_data", 8'd9, 0, 0, 32'h0, 4, 1, 32'hA5);
        check_eq("err_data_noflag", mem_flag, 32'h0);
        run_one("rb_mismatch", 8'd3, 0, -1, 32'h4, 5, 2, 32'd3);
        run_one("rb_highbits", 8'd5, 0, -1, 32'hABCD_0000, 5, 0, 32'd5);

        // Back-to-back: second result taken in the done cycle of the first.
        cfg_wait = '{0, 0, 0};
        cfg_err  = -1;
        cfg_xor  = 32'h0;
        acc1     = -1;
        acc2     = -1;
        done1    = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            result_class_i = (acc1 < 0) ? 8'd1 : 8'd2;
            result_valid_i = (acc2 < 0);
            step();
            if (result_valid_i && result_ready_o) begin
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end
            if (done_o && done1 < 0) done1 = cyc;
        end
        check_eq("b2b_first_latency", 32'(done1 - acc1), 32'd5);
        check_eq("b2b_second_accept", 32'(acc2 - acc1), 32'd5);
        check_eq("b2b_mem", mem_data, 32'd2);

        // Reset while the flag address phase is on the bus.
        result_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            result_valid_i = (i == 0);
            result_class_i = 8'd11;
            step();
        end
        check_eq("pre_rst_haddr", haddr, BASE + 32'd4);
        reset          = 1'b1;
        result_valid_i = 1'b0;
        @(negedge clk);
        reset_checks("mid_rst");
        reset = 1'b0;
        clear_model();
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            step();
            if (done_o) dones++;
        end
        check_eq("mid_rst_no_done", 32'(dones), 32'd0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (!m_busy) begin
                for (int k = 0; k < 3; k++) begin
                    cfg_wait[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                end
                cfg_err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
                case ($urandom_range(0, 3))
                    0:       cfg_xor = $urandom() & 32'hFFFF_FFE0;
                    1:       cfg_xor = 32'($urandom_range(1, 31));
                    default: cfg_xor = 32'h0;
                endcase
            end
            result_valid_i = ($urandom_range(0, 2) == 0);
            result_class_i = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30))
                                                         : 8'($urandom());
            step();
        end
        result_valid_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            step();
        end
        check_eq("drain_ready", 32'(result_ready_o), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ssd_result_writer.md
# ssd_result_writer

AHB-Lite initiator that takes a classifier result (letter index) from the inference datapath and publishes it to the seven-segment display slave at `0xD000_0000`. It writes the data register, then the done-flag register, and optionally reads the data register back to confirm the write. It sits between the classifier output and the shared AHB-Lite bus, on the master side of the SSD slave.

## Interface
Parameters:
- `BASE_ADDR`, `32'hD000_0000`, SSD data register address; done flag is at `BASE_ADDR+4`.
- `MAX_CLASS`, `23`, highest valid class index; larger inputs are saturated.
- `SAT_CODE`, `5'd31`, code written for out-of-range classes (the slave displays "99").
- `VERIFY`, `1`, 1 = read back the data register after the writes; 0 = skip the readback.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (100 MHz).
- `reset` in 1: synchronous, active-high reset.
- `result_valid_i` in 1: class result available.
- `result_class_i` in 8: raw class index.
- `result_ready_o` out 1: block is idle and can accept a result.
- `done_o` out 1: one-cycle pulse when a sequence ends.
- `status_o` out 2: result status, valid while `done_o`=1. 0 = OK, 1 = bus error, 2 = readback mismatch.
- `ahb_haddr_o` out 32, `ahb_hwrite_o` out 1, `ahb_hsize_o` out 3, `ahb_hburst_o` out 3, `ahb_hprot_o` out 4, `ahb_htrans_o` out 2, `ahb_hmastlock_o` out 1, `ahb_hwdata_o` out 32: AHB-Lite master outputs.
- `ahb_hrdata_i` in 32, `ahb_hready_i` in 1, `ahb_hresp_i` in 1: AHB-Lite slave responses.

## Operation
- Input mapping: `code = (class > MAX_CLASS) ? SAT_CODE : class[4:0]`. `code` is registered at accept, when `result_valid_i & result_ready_o`.
- Fixed AHB controls: `hsize` = 3'b010, `hburst` = 3'b000, `hprot` = 4'b0011, `hmastlock` = 0. All transfers are NONSEQ singles.
- FSM states:
  - `IDLE`: `htrans`=IDLE, `result_ready_o`=1. Accept → `A_DATA`.
  - `A_DATA`: address phase, `haddr`=BASE, write.
  - `A_FLAG`: data phase of `A_DATA`, `hwdata = {27'b0, code}`. Concurrent address phase, `haddr`=BASE+4, write.
  - `A_READ` (only if VERIFY=1): data phase of `A_FLAG`, `hwdata` = 1. Concurrent address phase, `haddr`=BASE, read.
  - `LAST`: `htrans`=IDLE, final data phase. This is either the flag write (`hwdata`=1, VERIFY=0) or the readback.
  - `ERR`: `htrans`=IDLE while the second cycle of the error response completes.
- State advances only on an edge where `hready_i`=1.
- On a wait state (`hready_i`=0, `hresp_i`=0), `haddr`, `hwrite`, `htrans` and `hwdata` hold stable.
- Readback: `hrdata[4:0]` is captured when `LAST` completes.
  - If it differs from `code`: `status_o`=2.
  - Otherwise `status_o`=0.
- Bus error: `hresp_i`=1 with `hready_i`=0 in any non-`IDLE` state sends the FSM to `ERR`. The next cycle drives `htrans`=IDLE, cancelling the pending address phase. When `hready_i`=1, the FSM goes to `IDLE` with `done_o`=1 and `status_o`=1. The remaining transfers are not issued.
- Boundary conditions:
  - `result_valid_i` while busy: ignored, since `result_ready_o`=0.
  - A new valid in the same cycle as `done_o`: accepted, because the FSM is already `IDLE`.
  - `reset` mid-sequence: all state and outputs return to reset values on the next edge. The pending transfer is abandoned.

## Timing
- Reset values:
  - `haddr`=0, `hwrite`=0, `htrans`=IDLE, `hwdata`=0.
  - `hsize`/`hburst`/`hprot`/`hmastlock` at their fixed values.
  - `result_ready_o`=1, `done_o`=0, `status_o`=0.
- All outputs are registered. There is no combinational path from AHB inputs to AHB outputs.
- Zero-wait-state latency, counting from the accept edge to `done_o`:
  - VERIFY=1: 5 cycles. Cycles are `A_DATA`, `A_FLAG`, `A_READ`, `LAST`, then `done_o` in `IDLE`.
  - VERIFY=0: 4 cycles.
- Each slave wait state adds one cycle.
- `done_o` is high for exactly one cycle per accepted result.

## Structure
- Shared package `ssd_ahb_pkg` holds:
  - `HTRANS_IDLE/BUSY/NONSEQ/SEQ`, `HSIZE_WORD`, `HPROT_DATA`.
  - `SSD_DATA_ADDR`, `SSD_FLAG_ADDR`, `SSD_SAT_CODE`.
  - Status codes.
  - The FSM state enum.
- Single module with no sub-module. The saturation mapping is an inline function in the package.

## Test plan
- Class 15, VERIFY=1, zero-wait slave → writes `0xD000_0000`=`0x0F`, then `0xD000_0004`=1, then a read. `done_o` 5 cycles after accept with `status_o`=0. The SSD slave reads back 15.
- Class 40 → `hwdata`=31 on the data write. The slave displays "99", `status_o`=0.
- Slave inserts 3 wait states on the flag write → address, control and `hwdata`=1 stay stable for 3 cycles. Latency is 8.
- `hresp` error on the data write → `htrans`=IDLE in the following cycle and no flag write is issued. `done_o` with `status_o`=1.
- Readback model returns 7 for written 3 → `status_o`=2.
- Back-to-back valids (class 1, then 2) with `result_valid_i` held high → second result accepted in the `done_o` cycle of the first. Reset asserted in `A_FLAG` → outputs at reset values next cycle and no `done_o`.
